disp_scan: RTL and testbench
============================

# disp_scan

Parametrised multiplexed seven-segment display driver that generalises the 3-to-8 active-low digit-select decoder into a full time-multiplexed scanner. Walks N_DIGITS digits with a programmable dwell time and an anti-ghosting blank gap. Drives one active-low digit select plus active-low segments per digit from a frame-stable snapshot of packed hex data. Sits between user logic and the board's common-anode display pins.

## Interface
- N_DIGITS, 8: digits scanned, 1..8
- SCAN_DIV, 50000: clk cycles a digit is lit, ≥1
- BLANK_CYC, 16: clk cycles all digits are off before each digit, ≥1
- clk  in  1  system clock, rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  scan enable
- data  in  4*N_DIGITS  hex nibbles; nibble i = data[4i+3:4i] drives digit i (digit 0 rightmost)
- dp  in  N_DIGITS  decimal point per digit, 1 = lit
- dig_en  in  N_DIGITS  per-digit enable; 0 = digit kept dark
- sel  out  N_DIGITS  digit select, active-low one-hot, or all-ones
- sg  out  8  segments, active-low; sg[0..6] = a..g, sg[7] = dp
- idx  out  clog2(N_DIGITS), min 1  digit currently addressed
- frame_tick  out  1  one-cycle pulse when idx wraps N_DIGITS-1 -> 0

## Operation
- States: IDLE, BLANK, SHOW.
- IDLE: sel all ones, sg = 8'hFF, idx = 0. Leaves on en=1 to BLANK with idx = 0.
- BLANK: sel all ones, sg = 8'hFF for BLANK_CYC cycles, then SHOW.
- SHOW: for SCAN_DIV cycles, sel[idx] = 0 when dig_en[idx]=1, else sel all ones; sg = font(nibble idx) with sg[7] = ~dp_snap[idx]. Then idx increments to BLANK. At idx = N_DIGITS-1, idx wraps to 0 and frame_tick pulses.
- Snapshot: data, dp and dig_en are latched on every entry to BLANK with idx = 0. A frame never mixes old and new data.
- Font, active-low, dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- en=0 in any state: next cycle enters IDLE. A partial frame is abandoned and frame_tick is not pulsed.
- Dwell counter width: clog2(max(SCAN_DIV, BLANK_CYC)). Counter restarts at 0 on every state entry.

## Timing
- All outputs are registered.
- Reset values: sel all ones, sg 8'hFF, idx 0, frame_tick 0, state IDLE.
- en rising at edge k: BLANK during cycles k+1..k+BLANK_CYC. sel[0] goes low at cycle k+BLANK_CYC+1.
- Digit period = BLANK_CYC + SCAN_DIV cycles. Frame period = N_DIGITS × that.
- frame_tick is high during the first BLANK cycle of each new frame, excluding the first frame after IDLE.
- rst_n low mid-scan forces the reset values immediately, without waiting for clk. Scanning resumes from IDLE after release.
- Never more than one sel bit is low. sel and sg change on the same edge.
- N_DIGITS=1: idx stays 0 and frame_tick pulses every digit period.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking.
  - Scanning downward from digit N_DIGITS-1, each snapshot nibble equal to 0 is shown dark (sg[6:0] = 7'h7F), up to the first non-zero nibble.
  - Digit 0 is never blanked.
  - dp is still driven on blanked digits.
  - sel behaviour is unchanged.
- Undefined: every enabled digit shows its font.

## Structure
- Package disp_pkg holds:
  - SEG_OFF = 8'hFF
  - the 16-entry font constant array
  - the state enum (IDLE, BLANK, SHOW)
- Sub-module hex7seg: purely combinational nibble -> 7-bit active-low font lookup, one instance on the selected snapshot nibble.

## Test plan
- Reset, then en=0 for 100 cycles -> sel=8'hFF, sg=8'hFF, idx=0, frame_tick=0 throughout.
- N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=2, data=16'h1234, dp=4'b0001, dig_en=4'hF.
  - Digit order 0..3 with sg 19, B0, A4, F9 and sel E, D, B, 7, each lit 4 cycles after 2 dark cycles.
  - frame_tick every 24 cycles.
- Change data to 16'hABCD mid-frame -> the current frame completes with 1234; the next frame shows D, C, B, A (A1, C6, 83, 88).
- dig_en=4'b1010 -> digits 0 and 2 keep sel all ones during their SHOW slots; timing unchanged.
- DISP_LZB_EN, data=16'h0050 -> digit 3 dark, digit 2 dark, digit 1 shows 92, digit 0 shows C0. data=16'h0000 -> only digit 0 shows C0.
- rst_n pulsed low mid-SHOW -> sel and sg go to FF without a clock edge. en=0 mid-frame -> IDLE next cycle with no frame_tick.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: blank pattern,
// active-low hex font and scan state encoding.
package disp_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low a..g in bits 6:0, bit 7 (dp) off.
  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

endpackage

// File: rtl/disp_hex7seg.sv
// Combinational hex nibble to active-low seven-segment (a..g) lookup.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  logic [7:0] code;

  assign code  = FONT[nib_i];
  assign seg_o = code[6:0];

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed common-anode seven-segment scanner with blank gap between digits.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module disp_scan
  import disp_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   dig_en,
  output logic [N_DIGITS-1:0]   sel,
  output logic [7:0]            sg,
  output logic [IDX_W-1:0]      idx,
  output logic                  frame_tick
);

  localparam int DWELL_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W     = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]            sg_q, sg_d;
  logic                  ft_q, ft_d;
  logic                  snap_en;

  logic [4*N_DIGITS-1:0] data_snap_q;
  logic [N_DIGITS-1:0]   dp_snap_q, den_snap_q;

  logic [3:0]            nib;
  logic [6:0]            font;
  logic                  dp_cur, den_cur, lzb_cur;
`ifdef DISP_LZB_EN
  logic                  zero_run;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    ft_d    = 1'b0;
    snap_en = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          snap_en = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            // Wrapping to digit 0 starts a new frame: resample inputs and tick.
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              ft_d    = 1'b1;
              snap_en = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  hex7seg u_font (
    .nib_i (nib),
    .seg_o (font)
  );

  // Outputs are computed from the next state so they register on the same edge as it.
  always_comb begin
    nib     = 4'h0;
    dp_cur  = 1'b0;
    den_cur = 1'b0;
    lzb_cur = 1'b0;
    sel_d   = '1;
`ifdef DISP_LZB_EN
    zero_run = 1'b1;
`endif
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
`ifdef DISP_LZB_EN
      zero_run = zero_run & (data_snap_q[4*i +: 4] == 4'h0);
`endif
      if (IDX_W'(i) == idx_d) begin
        nib     = data_snap_q[4*i +: 4];
        dp_cur  = dp_snap_q[i];
        den_cur = den_snap_q[i];
`ifdef DISP_LZB_EN
        lzb_cur = zero_run & (i != 0);
`endif
        sel_d[i] = ~((state_d == SHOW) & den_snap_q[i]);
      end
    end
    sg_d = SEG_OFF;
    if (state_d == SHOW) begin
      sg_d = {~dp_cur, (lzb_cur ? 7'h7F : font)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '1;
      sg_q    <= SEG_OFF;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      sg_q    <= sg_d;
      ft_q    <= ft_d;
    end
  end

  always_ff @(posedge clk) begin
    if (snap_en) begin
      data_snap_q <= data;
      dp_snap_q   <= dp;
      den_snap_q  <= dig_en;
    end
  end

  assign sel        = sel_q;
  assign sg         = sg_q;
  assign idx        = idx_q;
  assign frame_tick = ft_q;

  logic unused_ok;
  assign unused_ok = den_cur;

endmodule

// File: tb/tb_disp_scan.sv
// Randomised self-checking bench for disp_scan against a position-based frame model.
module tb_disp_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 2;
  localparam int DP = BC + SD;
  localparam int FR = N * DP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  dig_en = '0;
  logic [3:0]  sel;
  logic [7:0]  sg;
  logic [1:0]  idx;
  logic        frame_tick;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .dp         (dp),
    .dig_en     (dig_en),
    .sel        (sel),
    .sg         (sg),
    .idx        (idx),
    .frame_tick (frame_tick)
  );

  logic [7:0] font_t [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Model: position within the frame since scanning started, plus the frame snapshot.
  bit          m_act = 1'b0;
  int          m_pos = 0;
  bit          m_ft = 1'b0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_den = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      m_act = 1'b0;
      m_pos = 0;
      m_ft  = 1'b0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_pos = 0;
      m_ft  = 1'b0;
      s_data = data; s_dp = dp; s_den = dig_en;
    end else begin
      m_pos = (m_pos + 1) % FR;
      m_ft  = (m_pos == 0);
      if (m_pos == 0) begin
        s_data = data; s_dp = dp; s_den = dig_en;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0] e_sel;
    logic [7:0] e_sg;
    logic [1:0] e_idx;
    logic       e_ft;
    logic [3:0] nibv;
    int d, w;
    e_sel = 4'hF; e_sg = 8'hFF; e_idx = 2'd0; e_ft = 1'b0;
    if (m_act && rst_n) begin
      d = m_pos / DP;
      w = m_pos % DP;
      e_idx = 2'(d);
      e_ft  = m_ft;
      if (w >= BC) begin
        if (s_den[d]) e_sel[d] = 1'b0;
        nibv = 4'(s_data >> (4*d));
        e_sg = {~s_dp[d], font_t[nibv][6:0]};
`ifdef DISP_LZB_EN
        if (d > 0 && (s_data >> (4*d)) == 16'h0) e_sg[6:0] = 7'h7F;
`endif
      end
    end
    check("sel", {4'h0, sel}, {4'h0, e_sel});
    check("sg", sg, e_sg);
    check("idx", {6'h0, idx}, {6'h0, e_idx});
    check("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_sel", {4'h0, sel}, 8'h0F);
    check("rst_sg", sg, 8'hFF);
    step(3);
    rst_n = 1'b1;
    step(100);
    check("idle_sel", {4'h0, sel}, 8'h0F);

    data = 16'h1234; dp = 4'b0001; dig_en = 4'hF; en = 1'b1;
    step(1);
    check("blank0_sg", sg, 8'hFF);
    step(2);
    check("d0_sel", {4'h0, sel}, 8'h0E);
    check("d0_sg", sg, 8'h19);
    step(6);
    check("d1_sel", {4'h0, sel}, 8'h0D);
    check("d1_sg", sg, 8'hB0);
    step(6);
    check("d2_sel", {4'h0, sel}, 8'h0B);
    check("d2_sg", sg, 8'hA4);
    step(6);
    check("d3_sel", {4'h0, sel}, 8'h07);
    check("d3_sg", sg, 8'hF9);
    step(4);
    check("tick_hi", {7'h0, frame_tick}, 8'h01);
    step(1);
    check("tick_lo", {7'h0, frame_tick}, 8'h00);
    data = 16'hABCD;
    step(1);
    check("old_frame_sg", sg, 8'h19);
    step(30);
    check("new_frame_sel", {4'h0, sel}, 8'h0D);
    check("new_frame_sg", sg, 8'hC6);

    en = 1'b0;
    step(1);
    check("abort_sel", {4'h0, sel}, 8'h0F);
    check("abort_tick", {7'h0, frame_tick}, 8'h00);
    check("abort_idx", {6'h0, idx}, 8'h00);
    step(3);
    dig_en = 4'b1010; en = 1'b1;
    step(3);
    check("dark0_sel", {4'h0, sel}, 8'h0F);
    check("dark0_sg", sg, 8'h21);
    step(6);
    check("lit1_sel", {4'h0, sel}, 8'h0D);

    en = 1'b0; step(1);
    data = 16'h0050; dp = 4'h0; dig_en = 4'hF; en = 1'b1;
    step(3);
    check("z_d0", sg, 8'hC0);
    step(6);
    check("z_d1", sg, 8'h92);
    step(6);
    check("z_d2_sel", {4'h0, sel}, 8'h0B);
`ifdef DISP_LZB_EN
    check("z_d2", sg, 8'hFF);
    step(6);
    check("z_d3", sg, 8'hFF);
    en = 1'b0; step(1);
    data = 16'h0000; en = 1'b1;
    step(3);
    check("zz_d0", sg, 8'hC0);
    step(6);
    check("zz_d1", sg, 8'hFF);
`else
    check("z_d2", sg, 8'hC0);
    step(6);
    check("z_d3", sg, 8'hC0);
`endif

    en = 1'b0; step(1);
    en = 1'b1; step(4);
    check("pre_rst_sel", {4'h0, sel}, 8'h0E);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", {4'h0, sel}, 8'h0F);
    check("async_rst_sg", sg, 8'hFF);
    step(2);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) data = 16'($urandom);
      if ($urandom_range(0, 29) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 39) == 0) dig_en = 4'($urandom);
      if ($urandom_range(0, 149) == 0) en = 1'b0;
      else if ($urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rnd_rst_sg", sg, 8'hFF);
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
